// File: rtl/tube_pkg.sv
// Shared types and constants for the tube_ctrl display driver.
// The display shows four BCD digits, so anything above 9999 is clamped.
package tube_pkg;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // Number of digits driven on the tube.
  localparam int NUM_DIGITS = 4;

  // Largest value the four digits can show.
  localparam int MAX_VAL = 9999;

  // Width of the packed four-digit BCD field.
  localparam int BCD_TOTAL_W = BCD_W * NUM_DIGITS;

  // Width of the hold-time down-counter (HOLD_CYC tops out at 65535).
  localparam int HOLD_W = 16;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } tube_state_e;

  // Plain-vector aliases of the states.
  // The FSM register is a bare logic vector so it lines up with older
  // blocks that probe it directly.
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] CONV = ST_CONV;
  localparam logic [1:0] HOLD = ST_HOLD;

endpackage

// File: rtl/bcd_add3.sv
// One digit of the double-dabble correction step.
// Before each left shift, a digit of 5 or more gets 3 added.
// After the shift that digit then carries correctly into the next decade.
module bcd_add3
  import tube_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adjusted
);

  // Add 3 to any digit that would overflow a decade when doubled.
  always_comb begin
    adjusted = digit;
    if (digit >= BCD_W'(5)) begin
      adjusted = digit + BCD_W'(3);
    end
  end

endmodule

// File: rtl/tube_ctrl.sv
// Binary-to-BCD front end for the digital_tube display.
//
// Flow:
//   - A value is accepted in IDLE and clamped to 9999.
//   - In CONV it is converted one bit per cycle, MSB first, by shift-and-add-3.
//   - The finished digits are published in a single edge.
//   - HOLD then keeps the new value on screen for HOLD_CYC cycles before
//     another value is accepted.
//
// The digit outputs are registered separately from the working shift register.
// As a result the tube never shows a half-converted number.
module tube_ctrl
  import tube_pkg::*;
#(
  parameter int HOLD_CYC = 16,
  parameter int BIN_W    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_value,
  output logic             busy,
  output logic             ovf,
  output logic             dt_en,
  output logic [BCD_W-1:0] single_digit,
  output logic [BCD_W-1:0] ten_digit,
  output logic [BCD_W-1:0] hundred_digit,
  output logic [BCD_W-1:0] kilo_digit
);

  // Bit counter wide enough to hold BIN_W-1.
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  // Combined register layout: BCD digits on top, binary bits below.
  localparam int SR_W = BCD_TOTAL_W + BIN_W;

  localparam logic [BIN_W-1:0]  CLAMP_VAL = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(BIN_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  logic [1:0]             state;
  logic [SR_W-1:0]        shift_sr;
  logic [SR_W-1:0]        shift_pre;
  logic [SR_W-1:0]        shift_next;
  logic [BCD_TOTAL_W-1:0] bcd_adj;
  logic [BCD_TOTAL_W-1:0] bcd_result;
  logic [CNT_W-1:0]       bit_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   pend_ovf;
  logic                   accept;
  logic                   over_max;
  logic                   conv_last;
  logic [BIN_W-1:0]       capture_val;

  // Handshake.
  // A value is only taken in IDLE, and never while reset or clear is active.
  // This lets a clear that coincides with a request win cleanly.
  assign in_ready = (state == IDLE) && !rst && !clr;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Clamp anything the four digits cannot show.
  // The overflow is remembered until the converted digits are published.
  always_comb begin
    over_max    = (32'(in_value) > 32'(MAX_VAL));
    capture_val = in_value;
    if (over_max) begin
      capture_val = CLAMP_VAL;
    end
  end

  // One add-3 corrector per digit works on the BCD part of the shift register.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    bcd_add3 u_add3 (
      .digit    (shift_sr[BIN_W + d*BCD_W +: BCD_W]),
      .adjusted (bcd_adj[d*BCD_W +: BCD_W])
    );
  end

  // One conversion step.
  // The corrected digits and the remaining binary bits shift left together.
  // The binary MSB moves into the lowest digit.
  always_comb begin
    shift_pre  = {bcd_adj, shift_sr[BIN_W-1:0]};
    shift_next = shift_pre << 1;
    bcd_result = shift_next[SR_W-1:BIN_W];
    conv_last  = (state == CONV) && (bit_cnt == LAST_BIT);
  end

  // Controller FSM.
  // It also owns the working shift register, the bit counter and the hold
  // counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state    <= IDLE;
      shift_sr <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      pend_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= CONV;
            shift_sr <= {{BCD_TOTAL_W{1'b0}}, capture_val};
            bit_cnt  <= '0;
            pend_ovf <= over_max;
          end
        end
        CONV: begin
          shift_sr <= shift_next;
          if (conv_last) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Visible outputs.
  // They change only when a conversion completes, or on reset or clear.
  // The display enable latches on at the first completed value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      single_digit  <= '0;
      ten_digit     <= '0;
      hundred_digit <= '0;
      kilo_digit    <= '0;
      ovf           <= 1'b0;
      dt_en         <= 1'b0;
    end else if (conv_last) begin
      single_digit  <= bcd_result[0*BCD_W +: BCD_W];
      ten_digit     <= bcd_result[1*BCD_W +: BCD_W];
      hundred_digit <= bcd_result[2*BCD_W +: BCD_W];
      kilo_digit    <= bcd_result[3*BCD_W +: BCD_W];
      ovf           <= pend_ovf;
      dt_en         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tube_ctrl.sv
// Self-checking bench for tube_ctrl.
// The reference model works from decimal arithmetic on the accepted value.
// Expected timing comes from the accept edge.
module tb_tube_ctrl;

  localparam int BIN_W    = 14;
  localparam int HOLD_CYC = 16;
  localparam int PERIOD   = BIN_W + HOLD_CYC + 1;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_value;
  logic             busy;
  logic             ovf;
  logic             dt_en;
  logic [3:0]       single_digit;
  logic [3:0]       ten_digit;
  logic [3:0]       hundred_digit;
  logic [3:0]       kilo_digit;

  int checks = 0;
  int errors = 0;

  // Model of what the tube should currently show.
  logic [15:0] exp_disp;
  logic        exp_ovf;
  logic        exp_dt;

  tube_ctrl #(
    .HOLD_CYC (HOLD_CYC),
    .BIN_W    (BIN_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value      (in_value),
    .busy          (busy),
    .ovf           (ovf),
    .dt_en         (dt_en),
    .single_digit  (single_digit),
    .ten_digit     (ten_digit),
    .hundred_digit (hundred_digit),
    .kilo_digit    (kilo_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case something stalls forever.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] shown();
    return {kilo_digit, hundred_digit, ten_digit, single_digit};
  endfunction

  // Decimal reference: clamp, then split into digits by division.
  function automatic logic [15:0] to_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_digits"}, 32'(shown()), 32'h0);
    check_output({tag, "_ovf"}, 32'(ovf), 32'd0);
    check_output({tag, "_dt_en"}, 32'(dt_en), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 4 * PERIOD) begin
      tick();
      n++;
    end
    check_output("ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Accept one value and follow it through CONV and HOLD back to IDLE.
  task automatic apply_stimulus(input logic [BIN_W-1:0] v);
    int ready_hi;
    int busy_lo;
    ready_hi = 0;
    busy_lo  = 0;
    wait_ready();
    in_valid = 1'b1;
    in_value = v;
    tick();
    in_valid = 1'b0;
    in_value = BIN_W'($urandom);
    for (int j = 0; j <= BIN_W + HOLD_CYC; j++) begin
      if (j > 0) tick();
      if (j == BIN_W - 1) begin
        check_output("no_partial_digits", 32'(shown()), 32'(exp_disp));
        check_output("no_partial_ovf", 32'(ovf), 32'(exp_ovf));
        check_output("no_partial_dt_en", 32'(dt_en), 32'(exp_dt));
      end
      if (j == BIN_W) begin
        exp_disp = to_bcd(int'(v));
        exp_ovf  = (int'(v) > 9999);
        exp_dt   = 1'b1;
        check_output("digits", 32'(shown()), 32'(exp_disp));
        check_output("ovf", 32'(ovf), 32'(exp_ovf));
        check_output("dt_en", 32'(dt_en), 32'd1);
      end
      if (j < BIN_W + HOLD_CYC) begin
        if (in_ready !== 1'b0) ready_hi++;
        if (busy !== 1'b1) busy_lo++;
      end
    end
    check_output("ready_low_cycles", 32'(ready_hi), 32'd0);
    check_output("busy_high_cycles", 32'(busy_lo), 32'd0);
    check_output("ready_after_hold", 32'(in_ready), 32'd1);
    check_output("busy_after_hold", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [BIN_W-1:0] vals [3];
    int ready_bad;
    rst      = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    exp_disp = '0;
    exp_ovf  = 1'b0;
    exp_dt   = 1'b0;

    // Reset state.
    tick();
    tick();
    check_reset_values("reset");
    check_output("reset_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_output("ready_out_of_reset", 32'(in_ready), 32'd1);

    // Basic conversion and the clamp boundary.
    apply_stimulus(BIN_W'(1234));
    apply_stimulus(BIN_W'(10000));
    apply_stimulus(BIN_W'(16383));
    apply_stimulus(BIN_W'(9999));

    // Held valid with a changing value.
    // Only values present at accept edges count.
    vals[0]   = BIN_W'(5);
    vals[1]   = BIN_W'(6);
    vals[2]   = BIN_W'(7);
    ready_bad = 0;
    wait_ready();
    in_valid  = 1'b1;
    for (int i = 0; i <= 2 * PERIOD + BIN_W; i++) begin
      in_value = vals[i % 3];
      #1;
      if (in_ready !== ((i % PERIOD) == 0)) ready_bad++;
      tick();
      if ((i % PERIOD) == BIN_W) begin
        exp_disp = to_bcd(int'(vals[(i - BIN_W) % 3]));
        exp_ovf  = 1'b0;
        exp_dt   = 1'b1;
        check_output("held_valid_digits", 32'(shown()), 32'(exp_disp));
      end
    end
    in_valid = 1'b0;
    check_output("held_valid_ready_pattern", 32'(ready_bad), 32'd0);

    // Clear in the middle of a conversion.
    wait_ready();
    in_valid = 1'b1;
    in_value = BIN_W'(4321);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    clr = 1'b1;
    #1;
    check_output("clr_ready_low", 32'(in_ready), 32'd0);
    tick();
    clr = 1'b0;
    #1;
    exp_disp = '0;
    exp_ovf  = 1'b0;
    exp_dt   = 1'b0;
    check_reset_values("clr_conv");
    check_output("clr_ready_back", 32'(in_ready), 32'd1);

    // Clear together with a request: nothing is captured.
    clr      = 1'b1;
    in_valid = 1'b1;
    in_value = BIN_W'(77);
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_output("clr_accept_busy", 32'(busy), 32'd0);
    apply_stimulus(BIN_W'(42));

    // Reset during HOLD.
    // Reset held together with a request.
    wait_ready();
    in_valid = 1'b1;
    in_value = BIN_W'(1357);
    tick();
    in_valid = 1'b0;
    repeat (BIN_W) tick();
    check_output("pre_rst_digits", 32'(shown()), 32'(to_bcd(1357)));
    repeat (3) tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_value = BIN_W'(55);
    #1;
    check_output("rst_ready_low", 32'(in_ready), 32'd0);
    tick();
    check_reset_values("rst_hold");
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    exp_disp = '0;
    exp_ovf  = 1'b0;
    exp_dt   = 1'b0;
    check_reset_values("rst_valid");
    check_output("rst_ready_back", 32'(in_ready), 32'd1);

    // Reset during CONV leaves no partial digits.
    in_valid = 1'b1;
    in_value = BIN_W'(8888);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_reset_values("rst_conv");

    // Zero still enables the display.
    apply_stimulus(BIN_W'(0));

    // Randomized values with random idle gaps.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      apply_stimulus(BIN_W'($urandom_range(0, (1 << BIN_W) - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tube_ctrl.md
TUBE_CTRL -- requirements
Module: tube_ctrl

Interface
REQ-001 Parameter HOLD_CYC, default 16: minimum number of cycles a new display value is held before the next value is accepted; legal range 1..65535.
REQ-002 Parameter BIN_W, default 14: width of the binary input value.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port clr, input, 1: synchronous clear; blanks the display and aborts any conversion.
REQ-006 Port in_valid, input, 1: in_value is valid.
REQ-007 Port in_ready, output, 1: block can accept a value this cycle.
REQ-008 Port in_value, input, BIN_W: unsigned binary number to display.
REQ-009 Port busy, output, 1: high whenever state is not IDLE.
REQ-010 Port ovf, output, 1: the value currently displayed was clamped.
REQ-011 Port dt_en, output, 1: display enable for the downstream digital_tube.
REQ-012 Ports single_digit, ten_digit, hundred_digit, kilo_digit, output, 4 each: BCD digits for the downstream digital_tube.

Function
REQ-013 FSM states SHALL be IDLE, CONV and HOLD; in_ready = (state==IDLE) and not rst and not clr.
REQ-014 Accept: at an edge with in_valid and in_ready both high, the block SHALL capture in_value and move IDLE->CONV.
REQ-015 Any value above 9999 SHALL be clamped to 9999 at capture, with a pending overflow flag set; otherwise the pending flag is cleared.
REQ-016 CONV SHALL run a shift-and-add-3 (double-dabble) conversion for exactly BIN_W cycles, one bit per cycle, MSB first.
REQ-017 On the BIN_W-th edge after accept, the four digit outputs and ovf SHALL update in the same edge, dt_en SHALL go to 1, and state SHALL go CONV->HOLD; digit outputs never show intermediate values.
REQ-018 Latency: accept at edge k -> digits valid after edge k+BIN_W (14 with default parameters).
REQ-019 HOLD SHALL last exactly HOLD_CYC cycles via a down-counter, then go HOLD->IDLE; in_ready first rises after edge k+BIN_W+HOLD_CYC.
REQ-020 in_valid held high continuously SHALL be accepted once per BIN_W+HOLD_CYC+1 cycles; values presented while in_ready is low SHALL be ignored, not queued.
REQ-021 Digit outputs, ovf and dt_en SHALL hold their values in IDLE, CONV and HOLD; they change only per REQ-017, REQ-022 and REQ-024.
REQ-022 clr SHALL force state to IDLE, all digits to 0, and ovf and dt_en to 0 at the next edge, from any state.
REQ-023 clr and an accept in the same cycle: clr wins and no value is captured.
REQ-024 Once dt_en is 1, it SHALL stay 1 until rst or clr.

Reset
REQ-025 While rst is high at an edge: state IDLE, all digits 0, ovf 0, dt_en 0, busy 0, hold counter 0, shift register 0.
REQ-026 in_ready SHALL be 0 during any cycle in which rst is high.
REQ-027 rst asserted mid-CONV or mid-HOLD SHALL abandon the operation and leave no partial digit update.

Structure
REQ-028 Package tube_pkg SHALL hold the state enum typedef, BCD_W=4, NUM_DIGITS=4 and MAX_VAL=9999.
REQ-029 Sub-module bcd_add3 (combinational: add 3 when the nibble is >= 5) SHALL be instantiated four times, one per digit, in the conversion step.
REQ-030 The top level SHALL contain only the FSM, capture/clamp logic, shift register, hold counter and output registers.

Verification
REQ-031 in_value=1234, single-cycle valid -> after 14 edges kilo..single=1,2,3,4, ovf=0, dt_en=1; in_ready low for 14+16 cycles.
REQ-032 in_value=10000, then 16383 -> each displays 9,9,9,9 with ovf=1; next in_value=9999 -> 9,9,9,9 with ovf=0.
REQ-033 in_valid held high with values 5, 6, 7 changing every cycle -> only values sampled at accept edges 31 cycles apart are displayed.
REQ-034 Accept 4321 and pulse clr at CONV cycle 7 -> digits 0, dt_en=0, IDLE next cycle; a following accept of 42 -> 0,0,4,2.
REQ-035 rst during HOLD, and rst+in_valid in the same cycle -> all outputs return to reset values, nothing accepted; in_value=0 -> 0,0,0,0 with dt_en=1.
